clk_switch_ctrl: RTL
====================

# clk_switch_ctrl

Parametrised glitch-free clock-source switch controller for N clock sources. Runs in one control clock domain and drives per-source gate enables to downstream clock-gating cells, with break-before-make sequencing, a programmable dead time, a valid/ready request interface and automatic failover to a default source. It supersedes the two-input select-driven clock mux for all multi-source clock trees.

## Interface
- NUM_SRC, 4, number of clock sources (2..16)
- SEL_W, $clog2(NUM_SRC), width of select fields
- DEAD_CYCLES, 4, cycles with all gates off between sources (≥1)
- DEFAULT_SRC, 0, source enabled after reset and failover target (< NUM_SRC)

- clk  in  1  control clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  switch request valid
- req_sel  in  SEL_W  requested source index
- req_ready  out  1  request accepted when req_valid & req_ready
- src_ok  in  NUM_SRC  per-source alive flags, already synchronised to clk
- fail_en  in  1  enables automatic failover to DEFAULT_SRC
- gate_en  out  NUM_SRC  per-source gate enable; one-hot or all-zero
- cur_sel  out  SEL_W  currently or most recently selected source
- busy  out  1  switch sequence in progress
- switch_done  out  1  one-cycle pulse when a new gate_en goes high or a same-source request completes
- req_err  out  1  one-cycle pulse on rejected request
- fail_pulse  out  1  one-cycle pulse when failover starts

## Operation
- States: OFF (gates off, dead-time count), ACTIVE (one gate on, idle).
- Reset (rst_n low at an edge): state=OFF, counter=DEAD_CYCLES, gate_en=0, cur_sel=DEFAULT_SRC, busy=1, req_ready=0, all pulses 0. Applies mid-sequence; pending switch discarded.
- OFF: counter decrements each cycle; on the cycle it is 1, next edge sets gate_en[cur_sel]=1, busy=0, switch_done=1, state=ACTIVE.
- req_ready = (state==ACTIVE) & !failover_cond (combinational).
- Accepted request, decided at acceptance edge:
  - req_sel ≥ NUM_SRC or src_ok[req_sel]=0: rejected; req_err=1 next cycle; no other change.
  - req_sel == cur_sel: no gate change; switch_done=1 next cycle.
  - otherwise: next cycle gate_en=0, cur_sel=req_sel, busy=1, state=OFF, counter=DEAD_CYCLES.
- failover_cond = ACTIVE & fail_en & !src_ok[cur_sel] & (cur_sel≠DEFAULT_SRC) & src_ok[DEFAULT_SRC]. When true: same as a valid switch to DEFAULT_SRC, plus fail_pulse=1 next cycle. Failover has priority over a simultaneous request (request not accepted).
- Current source dead and DEFAULT_SRC dead or fail_en=0: gate stays on, no action.
- src_ok of target not rechecked during OFF; failover checks resume in ACTIVE.
- Counter width $clog2(DEAD_CYCLES+1); no wrap.
- Invariant: at most one gate_en bit high; never two sources enabled on the same cycle.

## Timing
- Out of reset: gate_en=0 for DEAD_CYCLES cycles after rst_n rises, gate_en[DEFAULT_SRC]=1 on the following cycle.
- Switch accepted at edge k: gate_en=0 for cycles k+1..k+DEAD_CYCLES, gate_en[new]=1 and switch_done from k+DEAD_CYCLES+1.
- req_ready low from k+1 until the switch_done cycle; high again on that cycle.
- Pulses exactly one cycle; all outputs registered except req_ready.

## Test plan
- Reset, DEAD_CYCLES=4: rst_n released -> gate_en=0000 for 4 cycles, then 0001, switch_done=1 once, cur_sel=0.
- Request sel=2, src_ok=1111, accepted at edge k -> gate_en=0000 on k+1..k+4, 0100 on k+5, switch_done at k+5, busy high k+1..k+4.
- Request sel=3 with src_ok[3]=0, then sel=5 (NUM_SRC=4, SEL_W=3 override) -> req_err pulse each, gate_en unchanged.
- Active on source 2, fail_en=1, src_ok[2] drops, req_valid sel=1 same cycle -> fail_pulse, request not accepted, gate_en 0100->0000 ×4->0001.
- rst_n low during dead time of a switch to 3 -> gate_en=0, cur_sel=0, full reset sequence reruns; source 3 never enabled.
- Random requests/src_ok for 10k cycles -> gate_en never multi-hot, ≥DEAD_CYCLES zero cycles between any two different enabled sources.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// -----------------------------------------------------------------------------
// clk_switch_ctrl
//
// Glitch-free clock-source switch controller for NUM_SRC clock sources.
// Lives entirely in the control clock domain and drives per-source gate
// enables to downstream clock-gating cells. A switch is break-before-make:
// every gate is held off for DEAD_CYCLES cycles before the new source is
// enabled. If the running source dies, the block can fail over to
// DEFAULT_SRC on its own.
//
// Parameters
//   NUM_SRC      number of clock sources (2..16)
//   SEL_W        width of the select fields (>= $clog2(NUM_SRC))
//   DEAD_CYCLES  cycles with every gate off between two sources (>= 1)
//   DEFAULT_SRC  source enabled after reset and the failover target
//
// Ports
//   clk          control clock, all logic on its rising edge
//   rst_n        synchronous active-low reset
//   req_valid    switch request valid
//   req_sel      requested source index
//   req_ready    request accepted on a cycle with req_valid & req_ready
//   src_ok       per-source alive flags, already synchronised to clk
//   fail_en      enables automatic failover to DEFAULT_SRC
//   gate_en      per-source gate enable, one-hot or all-zero
//   cur_sel      currently or most recently selected source
//   busy         switch sequence (dead time) in progress
//   switch_done  one-cycle pulse: new gate on, or same-source request done
//   req_err      one-cycle pulse: accepted request was rejected
//   fail_pulse   one-cycle pulse: failover started
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is combinational and only depends on
// the registered state and on the failover condition; req_valid may be
// raised at any time and the bench/requester must hold req_sel while
// req_valid is high and req_ready is low.
// -----------------------------------------------------------------------------
module clk_switch_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int SEL_W       = $clog2(NUM_SRC),
    parameter int DEAD_CYCLES = 4,
    parameter int DEFAULT_SRC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [SEL_W-1:0]   req_sel,
    output logic               req_ready,
    input  logic [NUM_SRC-1:0] src_ok,
    input  logic               fail_en,
    output logic [NUM_SRC-1:0] gate_en,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               busy,
    output logic               switch_done,
    output logic               req_err,
    output logic               fail_pulse
);

    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);

    localparam logic [0:0] ST_OFF    = 1'b0;  // all gates off, dead time running
    localparam logic [0:0] ST_ACTIVE = 1'b1;  // one gate on, idle

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES);
    localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_SRC);

    logic [0:0]         state;
    logic [CNT_W-1:0]   cnt;

    logic               req_ok;       // requested index in range and alive
    logic               cur_ok;       // currently selected source alive
    logic               def_ok;       // default source alive
    logic               failover_cond;
    logic [NUM_SRC-1:0] cur_onehot;

    // Index lookups done by comparison so an out-of-range req_sel simply
    // yields "not ok" instead of reading past the end of src_ok.
    always_comb begin
        req_ok     = 1'b0;
        cur_ok     = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req_sel == SEL_W'(i)) req_ok = src_ok[i];
            if (cur_sel == SEL_W'(i)) begin
                cur_ok        = src_ok[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    assign def_ok = src_ok[DEFAULT_SRC];

    // Failover only when it can actually help: the default source must be
    // alive and we must not already be on it.
    assign failover_cond = (state == ST_ACTIVE) && fail_en && !cur_ok &&
                           (cur_sel != DEF_SEL) && def_ok;

    assign req_ready = (state == ST_ACTIVE) && !failover_cond;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            cnt         <= CNT_LOAD;
            gate_en     <= '0;
            cur_sel     <= DEF_SEL;
            busy        <= 1'b1;
            switch_done <= 1'b0;
            req_err     <= 1'b0;
            fail_pulse  <= 1'b0;
        end else begin
            switch_done <= 1'b0;
            req_err     <= 1'b0;
            fail_pulse  <= 1'b0;
            case (state)
                ST_OFF: begin
                    // Target src_ok is deliberately not rechecked here; the
                    // failover check picks it up again once ACTIVE.
                    if (cnt == CNT_W'(1)) begin
                        gate_en     <= cur_onehot;
                        busy        <= 1'b0;
                        switch_done <= 1'b1;
                        state       <= ST_ACTIVE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (failover_cond) begin
                        gate_en    <= '0;
                        cur_sel    <= DEF_SEL;
                        busy       <= 1'b1;
                        cnt        <= CNT_LOAD;
                        state      <= ST_OFF;
                        fail_pulse <= 1'b1;
                    end else if (req_valid) begin
                        if (!req_ok) begin
                            req_err <= 1'b1;
                        end else if (req_sel == cur_sel) begin
                            switch_done <= 1'b1;
                        end else begin
                            gate_en <= '0;
                            cur_sel <= req_sel;
                            busy    <= 1'b1;
                            cnt     <= CNT_LOAD;
                            state   <= ST_OFF;
                        end
                    end
                end
            endcase
        end
    end

endmodule
